switch_debouncer: RTL and testbench

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

---
 rtl/switch_debouncer.sv | 131 +++++++++++++
 tb/tb_switch_debouncer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer: 2-flop synchronizer plus a per-channel 4-state FSM.
// Define DEBOUNCER_EDGE_EN to build the registered rise_out/fall_out pulses; otherwise they are tied low.
module switch_debouncer #(
  parameter int unsigned N             = 4,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] raw_in,
  output logic [N-1:0] level_out,
  output logic [N-1:0] rise_out,
  output logic [N-1:0] fall_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  logic [N-1:0] sync1;
  logic [N-1:0] sync2;
  logic [N-1:0] level_d;

  // Synchronizer for the asynchronous switch inputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lvl_d;

    always_ff @(posedge clk) begin
      if (!reset) begin
        state_q <= STABLE_LO;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // A new level is accepted only after STABLE_CYCLES+1 consecutive agreeing samples
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        STABLE_LO: begin
          if (sync2[i]) begin
            state_d = WAIT_HI;
            cnt_d   = '0;
          end
        end
        WAIT_HI: begin
          if (!sync2[i]) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end
        end
        STABLE_HI: begin
          if (!sync2[i]) begin
            state_d = WAIT_LO;
            cnt_d   = '0;
          end
        end
        WAIT_LO: begin
          if (sync2[i]) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end
      endcase
      lvl_d = (state_d == STABLE_HI) || (state_d == WAIT_LO);
    end

    assign level_d[i] = lvl_d;
  end

  // level_out is registered from the next state so it tracks the FSM with no extra lag
  always_ff @(posedge clk) begin
    if (!reset) begin
      level_out <= '0;
    end else begin
      level_out <= level_d;
    end
  end

`ifdef DEBOUNCER_EDGE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      rise_out <= '0;
      fall_out <= '0;
    end else begin
      rise_out <= level_d & ~level_out;
      fall_out <= ~level_d & level_out;
    end
  end
`else
  assign rise_out = '0;
  assign fall_out = '0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with a run-length reference model feeding a scoreboard queue.
module tb_switch_debouncer;

  localparam int unsigned N  = 4;
  localparam int unsigned SC = 4;
`ifdef DEBOUNCER_EDGE_EN
  localparam int EDGE = 1;
`else
  localparam int EDGE = 0;
`endif

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } exp_t;

  logic         clk    = 1'b0;
  logic         reset  = 1'b0;
  logic [N-1:0] raw_in = '0;
  logic [N-1:0] level_out;
  logic [N-1:0] rise_out;
  logic [N-1:0] fall_out;

  exp_t         sb[$];
  logic [N-1:0] m_s1  = '0;
  logic [N-1:0] m_s2  = '0;
  logic [N-1:0] m_lvl = '0;
  int           m_run[N];
  int           n_rise[N];
  int           n_fall[N];
  int           total = 0;
  int           bad   = 0;

  always #5 clk = ~clk;

  switch_debouncer #(
    .N            (N),
    .STABLE_CYCLES(SC),
    .CNT_W        (20)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .raw_in   (raw_in),
    .level_out(level_out),
    .rise_out (rise_out),
    .fall_out (fall_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict the post-edge outputs, then compare after the edge
  task automatic step(input logic [N-1:0] raw, input logic rst);
    exp_t         e;
    exp_t         got;
    logic [N-1:0] samp;
    @(negedge clk);
    raw_in = raw;
    reset  = rst;
    e.rise = '0;
    e.fall = '0;
    if (!rst) begin
      m_s1  = '0;
      m_s2  = '0;
      m_lvl = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      samp = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      for (int i = 0; i < N; i++) begin
        if (samp[i] !== m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == int'(SC) + 1) begin
            m_lvl[i] = samp[i];
            m_run[i] = 0;
            if (EDGE != 0) begin
              if (samp[i]) e.rise[i] = 1'b1;
              else e.fall[i] = 1'b1;
            end
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    e.lvl = m_lvl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      n_rise[i] += int'(rise_out[i]);
      n_fall[i] += int'(fall_out[i]);
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e   = sb.pop_front();
      got = '{lvl: level_out, rise: rise_out, fall: fall_out};
      chk("level", 32'(got.lvl), 32'(e.lvl));
      chk("rise", 32'(got.rise), 32'(e.rise));
      chk("fall", 32'(got.fall), 32'(e.fall));
      chk("rise_and_fall", 32'(rise_out & fall_out), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_run[i]  = 0;
      n_rise[i] = 0;
      n_fall[i] = 0;
    end

    // Held in reset with all inputs high
    for (int c = 0; c < 10; c++) begin
      step(4'hF, 1'b0);
      chk("rst_level", 32'(level_out), 32'd0);
      chk("rst_edges", 32'(rise_out | fall_out), 32'd0);
    end
    for (int c = 0; c < 4; c++) step(4'h0, 1'b1);

    // Clean 0->1 on channel 0: level rises at the 7th edge after first sample
    for (int c = 1; c <= 10; c++) begin
      step(4'b0001, 1'b1);
      if (c <= 6) chk("lat_lo", 32'(level_out[0]), 32'd0);
      if (c == 7) begin
        chk("lat_hi", 32'(level_out[0]), 32'd1);
        chk("lat_rise", 32'(rise_out[0]), 32'(EDGE));
      end
      if (c == 8) chk("rise_once", 32'(rise_out[0]), 32'd0);
    end

    // Short 3-cycle glitch on channel 1 is filtered
    for (int c = 0; c < 3; c++) step(4'b0011, 1'b1);
    for (int c = 0; c < 8; c++) step(4'b0001, 1'b1);
    chk("glitch_level", 32'(level_out[1]), 32'd0);
    chk("glitch_rise", 32'(n_rise[1]), 32'd0);
    chk("glitch_fall", 32'(n_fall[1]), 32'd0);

    // Channel 2 bounces every 2 cycles, then settles high
    for (int c = 0; c < 20; c++) step(((c >> 1) % 2 == 0) ? 4'b0101 : 4'b0001, 1'b1);
    for (int c = 0; c < 10; c++) step(4'b0101, 1'b1);
    chk("bounce_level", 32'(level_out[2]), 32'd1);
    chk("bounce_rise", 32'(n_rise[2]), 32'(EDGE));
    chk("bounce_fall", 32'(n_fall[2]), 32'd0);

    // Channel 0 falls back low
    for (int c = 1; c <= 8; c++) begin
      step(4'b0100, 1'b1);
      if (c == 6) chk("fall_lat_hi", 32'(level_out[0]), 32'd1);
      if (c == 7) chk("fall_lat_lo", 32'(level_out[0]), 32'd0);
    end
    chk("fall_count", 32'(n_fall[0]), 32'(EDGE));

    // Reset lands two cycles into channel 3's WAIT_HI
    for (int c = 0; c < 5; c++) step(4'b1100, 1'b1);
    for (int c = 0; c < 2; c++) step(4'b1100, 1'b0);
    chk("abort_level", 32'(level_out), 32'd0);
    chk("abort_rise3", 32'(n_rise[3]), 32'd0);

    // Channel 2 still high after reset is debounced again as a fresh rise
    for (int c = 0; c < 10; c++) step(4'b0100, 1'b1);
    chk("post_rst_rise3", 32'(n_rise[3]), 32'd0);
    chk("post_rst_level3", 32'(level_out[3]), 32'd0);
    chk("post_rst_level2", 32'(level_out[2]), 32'd1);
    chk("post_rst_rise2", 32'(n_rise[2]), 32'(2 * EDGE));
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
